an_tx_tone_gen: RTL and testbench
=================================

# an_tx_tone_gen

Acoustic tone transmitter for the analog link. It sends one byte as on-off keyed symbols of a fixed-frequency triangle tone, 440 Hz by default. The tone is emitted as a 1-bit first-order delta-sigma (PDM) stream to drive a speaker or RC filter. It is the transmit end paired with the receiver-side tone level detector: same tone frequency, amplitude recovered there as LV.

## Interface
- C_CK_Fs, 48_000_000: system clock frequency in Hz.
- C_DIV, 16: CK cycles per PDM tick, so the PDM rate is C_CK_Fs/C_DIV, 3 MHz by default. Must be ≥2.
- C_PH_INC, 2461: 24-bit phase increment per tick, equal to round(C_TONE_Fs·2^24/(C_CK_Fs/C_DIV)). Default gives 440 Hz.
- C_SYM_TICKs, 300_000: PDM ticks per symbol (100 ms). Must be ≥1.
- CK_i  in  1  system clock, all logic on the rising edge.
- ARST_i  in  1  asynchronous reset, active-high.
- REQ_i  in  1  start request, sampled every cycle.
- DATs_i  in  8  byte to send, latched on acceptance.
- LVs_i  in  12  tone amplitude, unsigned, latched on acceptance.
- BUSY_o  out  1  frame in progress.
- DONE_o  out  1  one-cycle pulse at the end of a frame.
- KEY_o  out  1  tone enabled for the current symbol.
- PDM_o  out  1  delta-sigma output bit.

## Operation
- Reset values: BUSY_o=0, DONE_o=0, KEY_o=0, PDM_o=0. Tick counter, phase, DS accumulator and symbol counter are 0. FSM is in IDLE.
- Tick: the counter counts 0..C_DIV-1 and wraps. `tick` is high in the cycle where the count equals C_DIV-1. The counter is free-running in IDLE.
- Acceptance: REQ_i=1 in IDLE has the following effects on that edge:
  - latch DATs_i and LVs_i;
  - clear the tick counter, phase accumulator and symbol counter;
  - enter LEAD with BUSY_o=1.
- REQ_i while BUSY_o=1 is ignored. DATs_i and LVs_i changes after acceptance have no effect.
- FSM: IDLE → LEAD (1 symbol) → BITS (8 symbols) → STOP (1 symbol) → IDLE.
- Symbol advance: the symbol counter counts ticks 0..C_SYM_TICKs-1. On the tick where the count is C_SYM_TICKs-1, the FSM advances to the next symbol or state.
- BITS order: MSB first, via a 3-bit bit index.
- KEY_o: 1 in LEAD. In BITS it equals the current data bit. 0 in STOP and IDLE. KEY_o is registered and changes on the same edge as the state or bit index.
- Phase: the 24-bit accumulator adds C_PH_INC on each tick, modulo 2^24.
- Triangle:
  - t = ph[23] ? ~ph[22:11] : ph[22:11], unsigned 12 bits;
  - s = t − 2048, signed −2048..2047.
- Sample: x = 2048 + ((s · LV) >>> 12) when KEY_o=1, else x = 2048.
  - The product is 25-bit signed and the shift is arithmetic.
  - x range is 0..4094 and is never negative or above 4095.
- Delta-sigma: on each tick, {c, acc[11:0]} ← acc + x, and PDM_o ← c. The ones density of PDM_o equals x/4096.
- Completion: on the final STOP tick, the next edge sets DONE_o=1 for one cycle and BUSY_o=0, and the FSM returns to IDLE. A new REQ_i is accepted in the cycle after DONE_o.
- ARST_i mid-frame: immediate return to reset values. No DONE_o. The latched byte is discarded.

## Timing
- PDM_o and acc update only on tick edges, so PDM_o holds for C_DIV cycles.
- First LEAD tick: C_DIV cycles after the acceptance edge.
- Frame length: BUSY_o is high for exactly 10·C_SYM_TICKs·C_DIV cycles.
- DONE_o is on the edge after the last tick. It coincides with BUSY_o falling.
- KEY_o transitions occur exactly C_SYM_TICKs·C_DIV cycles apart.

## Test plan
Bench overrides: C_DIV=4, C_SYM_TICKs=4, C_PH_INC=2^20.
- Reset:
  - Stimulus: hold ARST_i, then release with no REQ_i.
  - Required: all outputs 0 during reset.
  - Required: PDM_o then alternates 0,1,0,1 on successive ticks, since x=2048.
- Frame 0xA5, LV=4095:
  - Stimulus: REQ_i at cycle 0.
  - Required: KEY_o per symbol 1,1,0,1,0,0,1,0,1,0, each 16 cycles.
  - Required: BUSY_o high 160 cycles and DONE_o a single pulse at cycle 160.
- Amplitude zero:
  - Stimulus: frame 0xFF with LV=0.
  - Required: PDM_o keeps exact 0/1 alternation throughout.
- Full-scale density:
  - Stimulus: frame 0x80 with LV=4095.
  - Required: x per tick matches the triangle formula (period 16 ticks).
  - Required: the count of PDM_o ones over each 16-tick window is 8±1.
- Busy protection:
  - Stimulus: second REQ_i with DATs_i=0x00 at cycle 40 of a 0xA5 frame.
  - Required: KEY_o sequence unchanged and only one DONE_o.
- Reset mid-frame:
  - Stimulus: ARST_i pulse at cycle 70.
  - Required: BUSY_o and KEY_o go 0 asynchronously and no DONE_o.
  - Required: a new REQ_i afterwards produces a full 160-cycle frame.

Source files
------------

// File: rtl/an_tx_tone_gen.sv
// an_tx_tone_gen: on-off keyed triangle-tone transmitter for the analog link.
// Sends LEAD, 8 data bits MSB first and STOP as tone/no-tone symbols on a 1-bit PDM stream.
module an_tx_tone_gen #(
   parameter int unsigned C_CK_Fs     = 48_000_000,
   parameter int unsigned C_DIV       = 16,
   parameter int unsigned C_PH_INC    = 2461,
   parameter int unsigned C_SYM_TICKs = 300_000
) (
   input  logic        CK_i,
   input  logic        ARST_i,
   input  logic        REQ_i,
   input  logic [7:0]  DATs_i,
   input  logic [11:0] LVs_i,
   output logic        BUSY_o,
   output logic        DONE_o,
   output logic        KEY_o,
   output logic        PDM_o
);
   localparam int unsigned CNT_W = (C_DIV > 1) ? $clog2(C_DIV) : 1;
   localparam int unsigned SYM_W = (C_SYM_TICKs > 1) ? $clog2(C_SYM_TICKs) : 1;
   localparam int unsigned PH_W  = 24;
   localparam int unsigned SMP_W = 12;
   localparam int unsigned DAT_W = 8;

   // Reject configurations the tick and symbol counters cannot represent.
   if (C_DIV < 2 || C_SYM_TICKs < 1 || C_CK_Fs < C_DIV) begin : g_bad_cfg
      $error("an_tx_tone_gen: invalid C_CK_Fs/C_DIV/C_SYM_TICKs");
   end

   typedef enum logic [1:0] {S_IDLE, S_LEAD, S_BITS, S_STOP} state_t;

   state_t             state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [SYM_W-1:0]   sym_q, sym_d;
   logic [2:0]         bit_q, bit_d;
   logic [PH_W-1:0]    ph_q, ph_d;
   logic [SMP_W-1:0]   acc_q, acc_d;
   logic [DAT_W-1:0]   dat_q, dat_d;
   logic [SMP_W-1:0]   lv_q, lv_d;
   logic               busy_q, busy_d;
   logic               done_q, done_d;
   logic               key_q, key_d;
   logic               pdm_q, pdm_d;

   logic               tick_c;
   logic               sym_end_c;
   logic [2:0]         bit_dn_c;
   logic [SMP_W-1:0]   tri_c;
   logic signed [12:0] s_c;
   logic signed [24:0] prod_c;
   logic [SMP_W-1:0]   x_c;
   logic [SMP_W:0]     sum_c;

   assign tick_c    = (cnt_q == CNT_W'(C_DIV - 1));
   assign sym_end_c = (sym_q == SYM_W'(C_SYM_TICKs - 1));
   assign bit_dn_c  = bit_q - 3'd1;

   // Triangle from the phase MSBs, scaled by the latched level around mid-scale.
   assign tri_c  = ph_q[23] ? ~ph_q[22:11] : ph_q[22:11];
   assign s_c    = $signed({1'b0, tri_c}) - 13'sd2048;
   assign prod_c = 25'(s_c) * 25'($signed({1'b0, lv_q}));
   assign x_c    = key_q ? 12'(13'sd2048 + 13'(prod_c >>> 12)) : 12'd2048;
   assign sum_c  = {1'b0, acc_q} + {1'b0, x_c};

   always_comb begin
      state_d = state_q;
      cnt_d   = tick_c ? '0 : cnt_q + CNT_W'(1);
      sym_d   = sym_q;
      bit_d   = bit_q;
      ph_d    = ph_q;
      acc_d   = acc_q;
      pdm_d   = pdm_q;
      dat_d   = dat_q;
      lv_d    = lv_q;
      busy_d  = busy_q;
      done_d  = 1'b0;
      key_d   = key_q;

      // Oscillator and modulator run on every tick, idle or not.
      if (tick_c) begin
         ph_d           = ph_q + PH_W'(C_PH_INC);
         {pdm_d, acc_d} = sum_c;
      end

      if (state_q != S_IDLE && tick_c) begin
         sym_d = sym_end_c ? '0 : sym_q + SYM_W'(1);
      end

      case (state_q)
         S_IDLE: begin
            if (REQ_i) begin
               state_d = S_LEAD;
               cnt_d   = '0;
               ph_d    = '0;
               sym_d   = '0;
               dat_d   = DATs_i;
               lv_d    = LVs_i;
               busy_d  = 1'b1;
               key_d   = 1'b1;
            end
         end
         S_LEAD: begin
            if (tick_c && sym_end_c) begin
               state_d = S_BITS;
               bit_d   = 3'd7;
               key_d   = dat_q[7];
            end
         end
         S_BITS: begin
            if (tick_c && sym_end_c) begin
               if (bit_q == 3'd0) begin
                  state_d = S_STOP;
                  key_d   = 1'b0;
               end else begin
                  bit_d = bit_dn_c;
                  key_d = dat_q[bit_dn_c];
               end
            end
         end
         S_STOP: begin
            if (tick_c && sym_end_c) begin
               state_d = S_IDLE;
               busy_d  = 1'b0;
               done_d  = 1'b1;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge CK_i or posedge ARST_i) begin
      if (ARST_i) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         sym_q   <= '0;
         bit_q   <= '0;
         ph_q    <= '0;
         acc_q   <= '0;
         dat_q   <= '0;
         lv_q    <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         key_q   <= 1'b0;
         pdm_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         sym_q   <= sym_d;
         bit_q   <= bit_d;
         ph_q    <= ph_d;
         acc_q   <= acc_d;
         dat_q   <= dat_d;
         lv_q    <= lv_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         key_q   <= key_d;
         pdm_q   <= pdm_d;
      end
   end

   assign BUSY_o = busy_q;
   assign DONE_o = done_q;
   assign KEY_o  = key_q;
   assign PDM_o  = pdm_q;
endmodule

// File: tb/tb_an_tx_tone_gen.sv
// Self-checking bench for an_tx_tone_gen: fixed-expectation scenarios plus a
// cycle-level behavioural reference model of frames, tone samples and the modulator.
module tb_an_tx_tone_gen;
   localparam int unsigned DIV   = 4;
   localparam int unsigned SYM   = 4;
   localparam int unsigned PHI   = 32'd1 << 20;
   localparam int unsigned SYMCY = SYM * DIV;
   localparam int unsigned FRAME = 10 * SYMCY;

   logic        clk  = 1'b0;
   logic        arst = 1'b1;
   logic        req  = 1'b0;
   logic [7:0]  dat  = '0;
   logic [11:0] lv   = '0;
   logic        busy, done, key, pdm;

   int n_tests = 0;
   int n_fail  = 0;

   an_tx_tone_gen #(
      .C_CK_Fs    (48_000_000),
      .C_DIV      (DIV),
      .C_PH_INC   (PHI),
      .C_SYM_TICKs(SYM)
   ) dut (
      .CK_i  (clk),
      .ARST_i(arst),
      .REQ_i (req),
      .DATs_i(dat),
      .LVs_i (lv),
      .BUSY_o(busy),
      .DONE_o(done),
      .KEY_o (key),
      .PDM_o (pdm)
   );

   always #5 clk = ~clk;

   // ---------------- reference model ----------------
   int unsigned m_n    = 0;
   int unsigned m_acc  = 0;
   int unsigned m_ph   = 0;
   logic        m_busy = 1'b0;
   logic        m_done = 1'b0;
   logic        m_key  = 1'b0;
   logic        m_pdm  = 1'b0;
   logic [7:0]  m_dat  = '0;
   logic [11:0] m_lv   = '0;

   function automatic int tone_x(int unsigned ph, logic k, logic [11:0] amp);
      int unsigned idx, t;
      int s, p;
      if (!k) return 2048;
      idx = (ph >> 11) % 4096;
      t   = (ph >= (32'd1 << 23)) ? (4095 - idx) : idx;
      s   = int'(t) - 2048;
      p   = s * int'(amp);
      return 2048 + (p >>> 12);
   endfunction

   function automatic logic sym_key(logic [7:0] d, int unsigned i);
      if (i == 0) return 1'b1;
      if (i <= 8) return d[8 - i];
      return 1'b0;
   endfunction

   always @(posedge clk or posedge arst) begin : ref_model
      int unsigned n1, nacc, nph, si;
      logic nb, nk, nd, np;
      if (arst) begin
         m_n <= 0; m_acc <= 0; m_ph <= 0;
         m_busy <= 1'b0; m_done <= 1'b0; m_key <= 1'b0; m_pdm <= 1'b0;
      end else begin
         n1 = m_n + 1; nb = m_busy; nk = m_key; nd = 1'b0; np = m_pdm;
         nacc = m_acc; nph = m_ph;
         if (n1 % DIV == 0) begin
            nacc = m_acc + int'(tone_x(m_ph, m_key, m_lv));
            np   = (nacc >= 4096);
            nacc = nacc % 4096;
            nph  = (m_ph + PHI) % (32'd1 << 24);
            if (m_busy && ((n1 / DIV) % SYM == 0)) begin
               si = n1 / SYMCY;
               if (si == 10) begin nb = 1'b0; nd = 1'b1; nk = 1'b0; end
               else nk = sym_key(m_dat, si);
            end
         end
         if (!m_busy && req) begin
            n1 = 0; nb = 1'b1; nk = 1'b1; nph = 0;
            m_dat <= dat; m_lv <= lv;
         end
         m_n <= n1; m_acc <= nacc; m_ph <= nph;
         m_busy <= nb; m_done <= nd; m_key <= nk; m_pdm <= np;
      end
   end

   // ---------------- scenarios ----------------
   task automatic test_reset();
      arst = 1'b1; req = 1'b0;
      repeat (3) begin
         @(negedge clk);
         n_tests++;
         if ({busy, done, key, pdm} !== 4'b0000) begin
            n_fail++; $display("FAIL reset_hold: outputs=%b required 0000", {busy, done, key, pdm});
         end
      end
      arst = 1'b0;
      for (int j = 1; j <= 8; j++) begin
         repeat (DIV) @(negedge clk);
         n_tests++;
         if (pdm !== (j % 2 == 0)) begin
            n_fail++; $display("FAIL reset_alt tick%0d: pdm=%b required %b", j, pdm, (j % 2 == 0));
         end
         n_tests++;
         if ({busy, done, key} !== 3'b000) begin
            n_fail++; $display("FAIL reset_idle tick%0d: busy/done/key=%b required 000", j, {busy, done, key});
         end
      end
   endtask

   task automatic test_frame_a5(input logic protect);
      logic [9:0] ks = 10'b1101001010;
      int busy_cnt = 0, done_cnt = 0, si;
      logic exp_key;
      @(negedge clk); req = 1'b1; dat = 8'hA5; lv = 12'hFFF;
      for (int c = 0; c < int'(FRAME) + 12; c++) begin
         @(negedge clk); req = 1'b0;
         si = c / int'(SYMCY);
         exp_key = (c < int'(FRAME)) ? ks[9 - si] : 1'b0;
         n_tests++;
         if (key !== exp_key) begin
            n_fail++; $display("FAIL a5_key p%0b c%0d: key=%b required %b", protect, c, key, exp_key);
         end
         n_tests++;
         if (busy !== (c < int'(FRAME)) || done !== (c == int'(FRAME))) begin
            n_fail++; $display("FAIL a5_busy_done p%0b c%0d: busy=%b done=%b required %b %b",
                               protect, c, busy, done, (c < int'(FRAME)), (c == int'(FRAME)));
         end
         n_tests++;
         if (pdm !== m_pdm) begin
            n_fail++; $display("FAIL a5_pdm p%0b c%0d: pdm=%b required %b", protect, c, pdm, m_pdm);
         end
         busy_cnt += int'(busy);
         done_cnt += int'(done);
         if (protect && c == 39) begin req = 1'b1; dat = 8'h00; lv = 12'h000; end
      end
      n_tests++;
      if (busy_cnt != int'(FRAME) || done_cnt != 1) begin
         n_fail++; $display("FAIL a5_totals p%0b: busy_cycles=%0d dones=%0d required %0d 1",
                            protect, busy_cnt, done_cnt, FRAME);
      end
   endtask

   task automatic test_amp_zero();
      logic prev;
      @(negedge clk); req = 1'b1; dat = 8'hFF; lv = 12'h000;
      prev = pdm;
      for (int c = 0; c < int'(FRAME) + 8; c++) begin
         @(negedge clk); req = 1'b0;
         if (c == 0) prev = pdm;
         if (c > 0 && (c % int'(DIV)) == 0) begin
            n_tests++;
            if (pdm !== ~prev) begin
               n_fail++; $display("FAIL amp0_alt c%0d: pdm=%b required %b", c, pdm, ~prev);
            end
            prev = pdm;
         end
         n_tests++;
         if ({busy, done, key, pdm} !== {m_busy, m_done, m_key, m_pdm}) begin
            n_fail++; $display("FAIL amp0_model c%0d: bdkp=%b required %b", c,
                               {busy, done, key, pdm}, {m_busy, m_done, m_key, m_pdm});
         end
      end
   endtask

   task automatic test_full_scale();
      logic ones [40];
      int cnt;
      @(negedge clk); req = 1'b1; dat = 8'h80; lv = 12'hFFF;
      for (int c = 0; c < int'(FRAME) + 4; c++) begin
         @(negedge clk); req = 1'b0;
         if (c > 0 && (c % int'(DIV)) == 0 && c <= int'(FRAME)) ones[c / int'(DIV) - 1] = pdm;
         n_tests++;
         if ({busy, done, key, pdm} !== {m_busy, m_done, m_key, m_pdm}) begin
            n_fail++; $display("FAIL fs_model c%0d: bdkp=%b required %b", c,
                               {busy, done, key, pdm}, {m_busy, m_done, m_key, m_pdm});
         end
      end
      for (int w = 0; w + 16 <= 40; w++) begin
         cnt = 0;
         for (int i = 0; i < 16; i++) cnt += int'(ones[w + i]);
         n_tests++;
         if (cnt < 7 || cnt > 9) begin
            n_fail++; $display("FAIL fs_density w%0d: ones=%0d required 7..9", w, cnt);
         end
      end
   endtask

   task automatic test_back_to_back();
      logic eb, ed;
      @(negedge clk); req = 1'b1; dat = 8'h3C; lv = 12'($urandom);
      for (int c = 0; c < 330; c++) begin
         @(negedge clk);
         if (c == 300) req = 1'b0;
         eb = (c < 160) || (c > 160 && c < 321);
         ed = (c == 160) || (c == 321);
         n_tests++;
         if (busy !== eb || done !== ed) begin
            n_fail++; $display("FAIL b2b c%0d: busy=%b done=%b required %b %b", c, busy, done, eb, ed);
         end
         n_tests++;
         if ({key, pdm} !== {m_key, m_pdm}) begin
            n_fail++; $display("FAIL b2b_model c%0d: kp=%b required %b", c, {key, pdm}, {m_key, m_pdm});
         end
      end
   endtask

   task automatic test_reset_mid();
      int busy_cnt = 0, done_cnt = 0;
      @(negedge clk); req = 1'b1; dat = 8'($urandom); lv = 12'($urandom);
      for (int c = 0; c < 70; c++) begin
         @(negedge clk); req = 1'b0;
         n_tests++;
         if ({busy, done, key, pdm} !== {m_busy, m_done, m_key, m_pdm}) begin
            n_fail++; $display("FAIL mid_pre c%0d: bdkp=%b required %b", c,
                               {busy, done, key, pdm}, {m_busy, m_done, m_key, m_pdm});
         end
      end
      @(negedge clk); #1 arst = 1'b1; #1;
      n_tests++;
      if ({busy, done, key, pdm} !== 4'b0000) begin
         n_fail++; $display("FAIL mid_async: bdkp=%b required 0000", {busy, done, key, pdm});
      end
      @(negedge clk); arst = 1'b0;
      for (int c = 0; c < 12; c++) begin
         @(negedge clk);
         n_tests++;
         if (busy !== 1'b0 || done !== 1'b0) begin
            n_fail++; $display("FAIL mid_quiet c%0d: busy=%b done=%b required 0 0", c, busy, done);
         end
      end
      @(negedge clk); req = 1'b1; dat = 8'($urandom); lv = 12'($urandom);
      for (int c = 0; c < int'(FRAME) + 6; c++) begin
         @(negedge clk); req = 1'b0;
         busy_cnt += int'(busy);
         done_cnt += int'(done);
         n_tests++;
         if (done !== (c == int'(FRAME)) || {key, pdm} !== {m_key, m_pdm}) begin
            n_fail++; $display("FAIL mid_post c%0d: done=%b kp=%b required %b %b", c, done,
                               {key, pdm}, (c == int'(FRAME)), {m_key, m_pdm});
         end
      end
      n_tests++;
      if (busy_cnt != int'(FRAME) || done_cnt != 1) begin
         n_fail++; $display("FAIL mid_totals: busy_cycles=%0d dones=%0d required %0d 1",
                            busy_cnt, done_cnt, FRAME);
      end
   endtask

   task automatic test_random();
      for (int c = 0; c < 1500; c++) begin
         @(negedge clk);
         n_tests++;
         if ({busy, done, key, pdm} !== {m_busy, m_done, m_key, m_pdm}) begin
            n_fail++; $display("FAIL rand c%0d: bdkp=%b required %b", c,
                               {busy, done, key, pdm}, {m_busy, m_done, m_key, m_pdm});
         end
         req = ($urandom_range(0, 15) == 0);
         dat = 8'($urandom);
         lv  = 12'($urandom);
      end
      req = 1'b0;
   endtask

   initial begin
      test_reset();
      test_frame_a5(1'b0);
      test_amp_zero();
      test_full_scale();
      test_frame_a5(1'b1);
      test_back_to_back();
      test_reset_mid();
      test_random();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
